// File: rtl/uart_tx_slow.sv
// Oversampled-clock UART transmitter: valid/ready word in, start + data (LSB first)
// + optional parity + stop bits out on a registered, idle-high tx line.
module uart_tx_slow #(
    parameter int    DATA_WIDTH   = 8,
    parameter string PARITY_CHECK = "NONE",
    parameter int    CLK_FREQ     = 50000000,
    parameter int    BAUD_RATE    = 9600,
    parameter int    STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rdy,
    output logic                  tx,
    output logic                  busy
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_CYCLES < 2) ? 1 : $clog2(BIT_CYCLES);
    localparam int IDX_W      = (DATA_WIDTH < 2) ? 1 : $clog2(DATA_WIDTH);
    localparam bit PAR_EN     = (PARITY_CHECK != "NONE");
    localparam bit PAR_ODD    = (PARITY_CHECK == "ODD");
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    if (!(PARITY_CHECK == "NONE" || PARITY_CHECK == "ODD" || PARITY_CHECK == "EVEN")) begin : g_bad_parity
        $fatal(1, "uart_tx_slow: illegal PARITY_CHECK %s", PARITY_CHECK);
    end
    if (BIT_CYCLES < 2) begin : g_bad_baud
        $fatal(1, "uart_tx_slow: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (DATA_WIDTH < 2) begin : g_bad_width
        $fatal(1, "uart_tx_slow: DATA_WIDTH must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $fatal(1, "uart_tx_slow: STOP_BITS must be 1 or 2");
    end
    if (DATA_WIDTH > 8) begin : g_wide_warn
        $warning("uart_tx_slow: DATA_WIDTH above 8 is non-standard");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  rdy_q, rdy_d;
    logic                  busy_q, busy_d;

    // NOTE: state registers use non-blocking assignments; the reset is synchronous, so it sits inside the clocked branch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
        end
    end

    logic cnt_last;
    assign cnt_last = (cnt_q == '0);

    // NOTE: every next-state signal gets its hold value first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;

        if (state_q != S_IDLE && !cnt_last) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                rdy_d  = 1'b1;
                busy_d = 1'b0;
                if (i_vld && rdy_q) begin
                    shreg_d = i_data;
                    par_d   = PAR_ODD ? ~^i_data : ^i_data;
                    state_d = S_START;
                    tx_d    = 1'b0;
                    rdy_d   = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_MAX;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (cnt_last) begin
                    state_d = S_DATA;
                    tx_d    = shreg_q[0];
                    cnt_d   = CNT_MAX;
                end
            end
            S_DATA: begin
                if (cnt_last) begin
                    cnt_d = CNT_MAX;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = PAR_EN ? S_PARITY : S_STOP;
                        tx_d    = PAR_EN ? par_q : 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (cnt_last) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    cnt_d   = CNT_MAX;
                end
            end
            S_STOP: begin
                // The bit index is reused to count stop bits so the period counter stays one bit-period wide.
                if (cnt_last) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = S_IDLE;
                        idx_d   = '0;
                        rdy_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = CNT_MAX;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_rdy = rdy_q;
    assign tx    = tx_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_uart_tx_slow.sv
// Directed bench for uart_tx_slow: four instances (NONE, EVEN, ODD, two stop bits)
// on a shared clock/reset, each driven with hand-computed frames at BIT_CYCLES=16.
module tb_uart_tx_slow;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic [3:0] vld = 4'b0000;
    logic [3:0] rdy, txl, bsy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_slow #(.DATA_WIDTH(8), .PARITY_CHECK("NONE"), .CLK_FREQ(1600000), .BAUD_RATE(100000), .STOP_BITS(1))
        u_none (.clk(clk), .rst(rst), .i_vld(vld[0]), .i_data(data), .o_rdy(rdy[0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx_slow #(.DATA_WIDTH(8), .PARITY_CHECK("EVEN"), .CLK_FREQ(1600000), .BAUD_RATE(100000), .STOP_BITS(1))
        u_even (.clk(clk), .rst(rst), .i_vld(vld[1]), .i_data(data), .o_rdy(rdy[1]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx_slow #(.DATA_WIDTH(8), .PARITY_CHECK("ODD"), .CLK_FREQ(1600000), .BAUD_RATE(100000), .STOP_BITS(1))
        u_odd (.clk(clk), .rst(rst), .i_vld(vld[2]), .i_data(data), .o_rdy(rdy[2]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx_slow #(.DATA_WIDTH(8), .PARITY_CHECK("NONE"), .CLK_FREQ(1600000), .BAUD_RATE(100000), .STOP_BITS(2))
        u_stop2 (.clk(clk), .rst(rst), .i_vld(vld[3]), .i_data(data), .o_rdy(rdy[3]), .tx(txl[3]), .busy(bsy[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sends one word on instance k and checks every cycle of the n-bit frame.
    // exp is written first-sent bit leftmost. With disturb set, i_vld is
    // re-raised and i_data inverted part way through the frame.
    task automatic send_frame(input int k, input logic [7:0] d, input logic [15:0] exp,
                              input int n, input string tag, input bit disturb);
        int match;
        int hold;
        hold = 0;
        data   = d;
        vld[k] = 1'b1;
        check({tag, " rdy_before"}, 32'(rdy[k]), 32'd1);
        @(negedge clk);
        vld[k] = 1'b0;
        for (int b = 0; b < n; b++) begin
            match = 0;
            for (int c = 0; c < 16; c++) begin
                if (txl[k] === exp[n-1-b]) match++;
                if (rdy[k] === 1'b0 && bsy[k] === 1'b1) hold++;
                if (disturb && (b * 16 + c) == 40) begin
                    vld[k] = 1'b1;
                    data   = ~d;
                end
                if (disturb && (b * 16 + c) == 60) vld[k] = 1'b0;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d", tag, b), 32'(match), 32'd16);
        end
        check({tag, " busy_cycles"}, 32'(hold), 32'(n * 16));
        check({tag, " idle_after"}, {29'd0, txl[k], rdy[k], bsy[k]}, 32'b110);
    endtask

    logic [511:0] cap;
    logic [9:0]   obs_bits;
    int           f1, f2, run, waited;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("reset tx", 32'(txl), 32'hF);
        check("reset rdy", 32'(rdy), 32'h0);
        check("reset busy", 32'(bsy), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy after reset", 32'(rdy), 32'hF);

        // Scenario 1: no parity, 0xA5
        send_frame(0, 8'hA5, 16'(10'b0_10100101_1), 10, "none_a5", 1'b0);
        // Scenario 2: parity frames
        send_frame(1, 8'hA5, 16'(11'b0_10100101_0_1), 11, "even_a5", 1'b0);
        send_frame(2, 8'hA5, 16'(11'b0_10100101_1_1), 11, "odd_a5", 1'b0);
        send_frame(1, 8'h07, 16'(11'b0_11100000_1_1), 11, "even_07", 1'b0);
        // Scenario 4: two stop bits
        send_frame(3, 8'h3C, 16'(11'b0_00111100_11), 11, "stop2_3c", 1'b0);

        // Scenario 3: back-to-back with i_vld held high
        data   = 8'h00;
        vld[0] = 1'b1;
        @(negedge clk);
        data = 8'hFF;
        cap  = '0;
        for (int i = 0; i < 340; i++) begin
            cap[i] = txl[0];
            @(negedge clk);
        end
        vld[0] = 1'b0;
        f1 = -1;
        for (int i = 0; i < 340; i++) begin
            if (f1 < 0 && cap[i] == 1'b0) f1 = i;
        end
        f2 = -1;
        for (int i = 1; i < 340; i++) begin
            if (f2 < 0 && i > f1 && cap[i-1] == 1'b1 && cap[i] == 1'b0) f2 = i;
        end
        if (f1 < 0) f1 = 0;
        if (f2 < 1) f2 = 1;
        check("b2b first start", 32'(f1), 32'd0);
        check("b2b start spacing", 32'(f2 - f1), 32'd161);
        run = 0;
        for (int i = f2 - 1; i >= 0; i--) begin
            if (cap[i] == 1'b1) run++;
            else break;
        end
        check("b2b idle high run", 32'(run), 32'd17);
        for (int b = 0; b < 10; b++) obs_bits[9-b] = cap[f1 + 16 * b + 8];
        check("b2b frame1 bits", 32'(obs_bits), 32'(10'b0_00000000_1));
        for (int b = 0; b < 10; b++) obs_bits[9-b] = cap[f2 + 16 * b + 8];
        check("b2b frame2 bits", 32'(obs_bits), 32'(10'b0_11111111_1));
        waited = 0;
        while (rdy[0] !== 1'b1 && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("b2b drains to idle", 32'(rdy[0]), 32'd1);

        // Scenario 5: reset in the middle of a frame
        data   = 8'h5A;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        repeat (49) @(negedge clk);
        check("pre-abort busy", 32'(bsy[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort tx/busy/rdy", {29'd0, txl[0], bsy[0], rdy[0]}, 32'b100);
        rst = 1'b0;
        @(negedge clk);
        check("abort rdy returns", 32'(rdy[0]), 32'd1);
        send_frame(0, 8'h5A, 16'(10'b0_01011010_1), 10, "after_abort_5a", 1'b0);

        // Scenario 6: i_vld and i_data disturbed while busy
        send_frame(2, 8'h96, 16'(11'b0_01101001_1_1), 11, "odd_96_disturb", 1'b1);
        repeat (3) @(negedge clk);
        check("no stray transfer", {30'd0, bsy[2], txl[2]}, 32'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
